// File: rtl/led_pattern_gen.sv
// LED pattern generator: divided-clock stepper producing fill/drain,
// shift-wrap, bounce and blink patterns on N LEDs.
//
// Ports:
//   clk_50M    in   system clock, all state on rising edge
//   reset      in   asynchronous active-high reset
//   en         in   step enable, 0 freezes divider and pattern
//   mode       in   [1:0] 0 fill/drain, 1 shift-wrap, 2 bounce, 3 blink
//   out        out  [N-1:0] registered LED drive
//   step       out  one-cycle pulse on every pattern step
//   cycle_done out  one-cycle pulse on the step closing a period
module led_pattern_gen #(
    parameter int unsigned N   = 8,
    parameter int unsigned DIV = 12500000
) (
    input  logic         clk_50M,
    input  logic         reset,
    input  logic         en,
    input  logic [1:0]   mode,
    output logic [N-1:0] out,
    output logic         step,
    output logic         cycle_done
);

    typedef enum logic {
        PH_FILL,
        PH_DRAIN
    } phase_t;

    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ZERO = '0;
    localparam logic [N-1:0] ONES = '1;

    logic [31:0]  r_cnt;
    logic [N-1:0] r_out;
    logic [1:0]   r_mode_q;
    phase_t       r_ph;
    logic         r_step;
    logic         r_cd;

    logic         w_tick;
    logic [N-1:0] w_fill;
    logic [N-1:0] w_drain;
    logic [N-1:0] w_rotl;
    logic [N-1:0] w_shl;
    logic [N-1:0] w_shr;
    logic [N-1:0] w_out_nx;
    phase_t       w_ph_nx;
    logic         w_cd_nx;

    assign w_tick  = en && (r_cnt == DIV - 32'd1);
    assign w_fill  = {r_out[N-2:0], 1'b1};
    assign w_drain = {r_out[N-2:0], 1'b0};
    assign w_rotl  = {r_out[N-2:0], r_out[N-1]};
    assign w_shl   = r_out << 1;
    assign w_shr   = r_out >> 1;

    // Divider: holds while disabled, wraps on the step cycle.
    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            r_cnt <= 32'd0;
        end else if (en) begin
            if (w_tick) r_cnt <= 32'd0;
            else        r_cnt <= r_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            r_out    <= ZERO;
            r_mode_q <= 2'd0;
            r_ph     <= PH_FILL;
            r_step   <= 1'b0;
            r_cd     <= 1'b0;
        end else begin
            r_out    <= w_out_nx;
            r_ph     <= w_ph_nx;
            r_step   <= w_tick;
            r_cd     <= w_cd_nx;
            if (w_tick) r_mode_q <= mode;
        end
    end

    always_comb begin
        w_out_nx = r_out;
        w_ph_nx  = r_ph;
        w_cd_nx  = 1'b0;
        if (w_tick) begin
            if (mode != r_mode_q) begin
                // New mode: load its start value, no advance this step.
                w_ph_nx = PH_FILL;
                if (mode == 2'd1 || mode == 2'd2) w_out_nx = ONE;
                else                              w_out_nx = ZERO;
            end else begin
                unique case (r_mode_q)
                    2'd0: begin
                        if (r_ph == PH_FILL) begin
                            w_out_nx = w_fill;
                            if (w_fill == ONES) w_ph_nx = PH_DRAIN;
                        end else begin
                            w_out_nx = w_drain;
                            if (w_drain == ZERO) begin
                                w_ph_nx = PH_FILL;
                                w_cd_nx = 1'b1;
                            end
                        end
                    end
                    2'd1: begin
                        w_ph_nx  = PH_FILL;
                        w_out_nx = w_rotl;
                        w_cd_nx  = (w_rotl == ONE);
                    end
                    2'd2: begin
                        // Turn around as soon as an end is reached so each
                        // end position is shown for a single step.
                        if (r_ph == PH_FILL) begin
                            w_out_nx = w_shl;
                            if (w_shl[N-1]) w_ph_nx = PH_DRAIN;
                        end else begin
                            w_out_nx = w_shr;
                            if (w_shr == ONE) begin
                                w_ph_nx = PH_FILL;
                                w_cd_nx = 1'b1;
                            end
                        end
                    end
                    2'd3: begin
                        w_ph_nx  = PH_FILL;
                        w_out_nx = (r_out == ZERO) ? ONES : ZERO;
                        w_cd_nx  = (r_out != ZERO);
                    end
                    default: begin
                        w_out_nx = r_out;
                    end
                endcase
            end
        end
    end

    assign out        = r_out;
    assign step       = r_step;
    assign cycle_done = r_cd;

endmodule
